// File: rtl/rr_arb_mux.sv
// N:1 round-robin arbitrated multiplexer with a one-entry registered output stage.
// Grant is combinational from the rr pointer and in_valid; only out_ready reaches in_ready.
module rr_arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] ch_data [N_IN];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] last_q,      last_d;

    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;

    for (genvar g = 0; g < N_IN; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Scan from the channel after the last winner, wrapping; first valid channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            scan_idx = SEL_W'((32'(last_q) + k) % N_IN);
            if (!grant_vld && in_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = load_en && grant_vld && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Load on transfer, otherwise drain; data and tag hold after drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant_idx];
            out_sel_d   = grant_idx;
            last_d      = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= SEL_W'(N_IN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arb_mux;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = $clog2(N);

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_sel;
    logic             out_ready;

    int n_cmp;
    int n_bad;

    // Reference model state: occupancy, held word, tag, last winner.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_last;

    rr_arb_mux #(.WIDTH(W), .N_IN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 1; k <= int'(N); k++) begin
            int c;
            c = (m_last + k) % int'(N);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant(in_valid);
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_ch(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        logic [N-1:0] r;
        int g;
        logic [W-1:0] d;
        r = model_ready();
        g = model_grant(in_valid);
        d = (g >= 0) ? in_data[g*W +: W] : '0;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = N - 1;
        end else if (r != '0) begin
            m_valid = 1'b1; m_data = d; m_sel = g; m_last = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, $urandom);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== '0) begin
                n_bad++;
                $display("FAIL reset_in_ready cyc=%0d got=%b exp=0000", c, in_ready);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_single_source();
        rst = 1'b0; in_valid = 4'b0100; out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, $urandom);
        set_ch(2, 32'hDEAD_BEEF);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_in_ready got=%b exp=0100", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=deadbeef s=2", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_ch(i, 32'h1000_0000 + W'(i));
        for (int c = 0; c < 8; c++) begin
            logic [N-1:0] exp_r;
            exp_r = '0;
            exp_r[c % N] = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== exp_r) begin
                n_bad++;
                $display("FAIL rr_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_r);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || int'(out_sel) != c % N || out_data !== 32'h1000_0000 + W'(c % N)) begin
                n_bad++;
                $display("FAIL rr_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=%0d", c, out_valid, out_sel, out_data, c % N);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        in_valid = 4'b0010; out_ready = 1'b1;
        set_ch(1, $urandom);
        held = in_data[1*W +: W];
        tick();
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < N; i++) set_ch(i, $urandom);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== '0) begin
                n_bad++;
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=0000", c, in_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== held) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b s=%0d d=%h exp v=1 s=1 d=%h", c, out_valid, out_sel, out_data, held);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL bp_release got=%b exp=0100", in_ready);
        end
        tick();
        n_cmp++;
        if (out_sel !== 2'd2 || out_data !== in_data[2*W +: W]) begin
            n_bad++;
            $display("FAIL bp_after got s=%0d d=%h exp s=2 d=%h", out_sel, out_data, in_data[2*W +: W]);
        end
    endtask

    task automatic test_skip_wrap();
        int exp_seq [3] = '{1, 3, 1};
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 4'b1000; out_ready = 1'b1;
        tick();
        in_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            logic [N-1:0] exp_r;
            exp_r = '0;
            exp_r[exp_seq[c]] = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== exp_r) begin
                n_bad++;
                $display("FAIL skip_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_r);
            end
            tick();
            n_cmp++;
            if (int'(out_sel) != exp_seq[c] || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL skip_out cyc=%0d got s=%0d v=%b exp s=%0d v=1", c, out_sel, out_valid, exp_seq[c]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 4'b0100;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== '0) begin
            n_bad++;
            $display("FAIL rst_stall_in_ready got=%b exp=0000", in_ready);
        end
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stall_valid got=%b exp=0", out_valid);
        end
        in_valid = 4'b1001; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_stall_grant got=%b exp=0001", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== in_data[0 +: W]) begin
            n_bad++;
            $display("FAIL rst_stall_out got v=%b s=%0d d=%h exp v=1 s=0 d=%h", out_valid, out_sel, out_data, in_data[0 +: W]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] exp_r;
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) set_ch(i, $urandom);
            #1;
            exp_r = model_ready();
            n_cmp++;
            if (in_ready !== exp_r) begin
                n_bad++;
                $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_r);
            end
            tick();
            n_cmp++;
            if (out_valid !== m_valid || out_data !== m_data || int'(out_sel) != m_sel) begin
                n_bad++;
                $display("FAIL rand_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                         c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = N - 1;
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
